// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Brief    : Shared types and opcodes for the multi-cycle RV32I sequencer.
//  Revision : 1.0
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_WB_MEM = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_LUI    = 4'd9,
        S_WB_ALU = 4'd10,
        S_BRANCH = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // Encoding is shared with the immediate extender.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2,
        SRCA_ZERO  = 2'd3
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_DATA   = 2'd1,
        RES_ALU    = 2'd2
    } result_src_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

endpackage
`default_nettype wire

// File: rtl/ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_outdec
//  Brief    : Combinational control-output decode from state, IR fields, zero.
//  Revision : 1.0
// ============================================================================
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_addr_src,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_reg_write,
    output imm_src_t    o_imm_src,
    output alu_src_a_t  o_alu_src_a,
    output alu_src_b_t  o_alu_src_b,
    output alu_op_t     o_alu_op,
    output result_src_t o_result_src,
    output logic        o_illegal_instr
);

    always_comb begin
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_addr_src      = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_imm_src       = IMM_NONE;
        o_alu_src_a     = SRCA_PC;
        o_alu_src_b     = SRCB_RS2;
        o_alu_op        = ALU_ADD;
        o_result_src    = RES_ALUOUT;
        o_illegal_instr = 1'b0;

        case (i_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write   = 1'b1;
                    o_pc_write   = 1'b1;
                    o_alu_src_a  = SRCA_PC;
                    o_alu_src_b  = SRCB_FOUR;
                    o_alu_op     = ALU_ADD;
                    o_result_src = RES_ALU;
                end
            end
            S_DECODE: begin
                // Branch/jump target is computed speculatively here.
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == c_op_jal) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = (i_opcode == c_op_load) ? IMM_I : IMM_S;
            end
            S_MEMRD: begin
                o_mem_req  = 1'b1;
                o_addr_src = 1'b1;
            end
            S_MEMWR: begin
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b1;
                o_addr_src = 1'b1;
            end
            S_WB_MEM: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_RS2;
                o_alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = IMM_I;
                o_alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                o_alu_src_a = SRCA_ZERO;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = IMM_U;
            end
            S_WB_ALU: begin
                o_result_src = RES_ALUOUT;
                o_reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a  = SRCA_RS1;
                o_alu_src_b  = SRCB_RS2;
                o_alu_op     = ALU_SUB;
                o_result_src = RES_ALUOUT;
                o_pc_write   = ((i_funct3 == c_f3_beq) &&  i_zero) ||
                               ((i_funct3 == c_f3_bne) && !i_zero);
            end
            S_JAL: begin
                o_alu_src_a  = SRCA_OLDPC;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALUOUT;
                o_pc_write   = 1'b1;
            end
            S_TRAP: begin
                o_illegal_instr = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Brief    : Multi-cycle RV32I control sequencer with retire counter and trap.
//  Revision : 1.0
// ============================================================================
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [2:0]         imm_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
    output logic               illegal_instr,
    output logic [D_WIDTH-1:0] instret
);

    state_t             r_state;
    state_t             w_next;
    logic               w_retire;
    logic [D_WIDTH-1:0] r_instret;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    // Remaining IR bits are consumed by the datapath, not the sequencer.
    logic w_unused_instr;
    assign w_unused_instr = &{1'b0, instr[D_WIDTH-1:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    c_op_load, c_op_store: w_next = S_MEMADR;
                    c_op_r:                w_next = S_EXEC_R;
                    c_op_i:                w_next = S_EXEC_I;
                    c_op_branch:           w_next = S_BRANCH;
                    c_op_jal:              w_next = S_JAL;
                    c_op_lui:              w_next = S_LUI;
                    default:               w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (w_opcode == c_op_load) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_WB_MEM;
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_MEM: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_JAL: w_next = S_WB_ALU;
            S_WB_ALU: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                if ((w_funct3 == c_f3_beq) || (w_funct3 == c_f3_bne)) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_RST;
        endcase
    end

    imm_src_t    w_imm_src;
    alu_src_a_t  w_alu_src_a;
    alu_src_b_t  w_alu_src_b;
    alu_op_t     w_alu_op;
    result_src_t w_result_src;

    ctrl_outdec u_outdec (
        .i_state         (r_state),
        .i_opcode        (w_opcode),
        .i_funct3        (w_funct3),
        .i_zero          (zero),
        .i_mem_ready     (mem_ready),
        .o_mem_req       (mem_req),
        .o_mem_we        (mem_we),
        .o_addr_src      (addr_src),
        .o_ir_write      (ir_write),
        .o_pc_write      (pc_write),
        .o_reg_write     (reg_write),
        .o_imm_src       (w_imm_src),
        .o_alu_src_a     (w_alu_src_a),
        .o_alu_src_b     (w_alu_src_b),
        .o_alu_op        (w_alu_op),
        .o_result_src    (w_result_src),
        .o_illegal_instr (illegal_instr)
    );

    assign imm_src    = w_imm_src;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign alu_op     = w_alu_op;
    assign result_src = w_result_src;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Brief    : Self-checking bench; expected per-cycle outputs built per instruction.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    localparam int A_PC = 0, A_OLD = 1, A_RS1 = 2, A_ZERO = 3;
    localparam int B_RS2 = 0, B_IMM = 1, B_FOUR = 2;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_FN = 2;
    localparam int R_ALUOUT = 0, R_DATA = 1, R_ALU = 2;
    localparam int IM_I = 1, IM_S = 2, IM_B = 3, IM_U = 4, IM_J = 5;

    logic        clk = 1'b0;
    logic        rst_n, zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [2:0]  imm_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal_instr(illegal_instr), .instret(instret)
    );

    typedef struct packed {
        logic        mem_req, mem_we, addr_src, ir_write, pc_write, reg_write;
        logic [2:0]  imm;
        logic [1:0]  a, b, op, res;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        logic        rst_n, ready, zero, chk;
        logic [31:0] instr;
        exp_t        e;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_ret;
    int          passed = 0;
    int          total  = 0;

    function automatic exp_t idle();
        exp_t e = '0;
        e.ret = m_ret;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input exp_t e, input logic ready, input logic z, input logic [31:0] ins);
        cyc_t c;
        c.rst_n = 1'b1; c.ready = ready; c.zero = z; c.chk = 1'b1; c.instr = ins; c.e = e;
        q.push_back(c);
    endtask

    // Reset asserted in the last queued cycle and the next, then released.
    task automatic reset_tail(input logic [31:0] ins);
        exp_t e;
        q[q.size()-1].rst_n = 1'b0;
        m_ret = 0;
        e = idle();
        push(e, rbit(), rbit(), ins);
        q[q.size()-1].rst_n = 1'b0;
        push(e, rbit(), rbit(), ins);
    endtask

    task automatic trap(input logic [31:0] ins);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e = idle(); e.ill = 1'b1;
            push(e, rbit(), rbit(), ins);
        end
        reset_tail(ins);
    endtask

    task automatic wb_alu(input logic [31:0] ins);
        exp_t e = idle();
        e.res = 2'(R_ALUOUT); e.reg_write = 1'b1;
        push(e, rbit(), rbit(), ins);
        m_ret++;
    endtask

    task automatic add_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input bit abort_mem);
        exp_t       e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        for (int i = 0; i < fw; i++) begin
            e = idle(); e.mem_req = 1'b1;
            push(e, 1'b0, rbit(), ins);
        end
        e = idle();
        e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.a = 2'(A_PC); e.b = 2'(B_FOUR); e.op = 2'(OP_ADD); e.res = 2'(R_ALU);
        push(e, 1'b1, rbit(), ins);
        e = idle();
        e.a = 2'(A_OLD); e.b = 2'(B_IMM);
        e.imm = (opc == 7'b1101111) ? 3'(IM_J) : 3'(IM_B);
        push(e, rbit(), rbit(), ins);
        case (opc)
            7'b0000011, 7'b0100011: begin
                e = idle(); e.a = 2'(A_RS1); e.b = 2'(B_IMM);
                e.imm = (opc == 7'b0000011) ? 3'(IM_I) : 3'(IM_S);
                push(e, rbit(), rbit(), ins);
                e = idle(); e.mem_req = 1'b1; e.addr_src = 1'b1;
                e.mem_we = (opc == 7'b0100011);
                for (int i = 0; i < mw; i++) begin
                    push(e, 1'b0, rbit(), ins);
                    if (abort_mem) begin
                        reset_tail(ins);
                        return;
                    end
                end
                push(e, 1'b1, rbit(), ins);
                if (opc == 7'b0000011) begin
                    e = idle(); e.res = 2'(R_DATA); e.reg_write = 1'b1;
                    push(e, rbit(), rbit(), ins);
                end
                m_ret++;
            end
            7'b0110011: begin
                e = idle(); e.a = 2'(A_RS1); e.b = 2'(B_RS2); e.op = 2'(OP_FN);
                push(e, rbit(), rbit(), ins);
                wb_alu(ins);
            end
            7'b0010011: begin
                e = idle(); e.a = 2'(A_RS1); e.b = 2'(B_IMM); e.imm = 3'(IM_I); e.op = 2'(OP_FN);
                push(e, rbit(), rbit(), ins);
                wb_alu(ins);
            end
            7'b0110111: begin
                e = idle(); e.a = 2'(A_ZERO); e.b = 2'(B_IMM); e.imm = 3'(IM_U);
                push(e, rbit(), rbit(), ins);
                wb_alu(ins);
            end
            7'b1100011: begin
                e = idle(); e.a = 2'(A_RS1); e.b = 2'(B_RS2); e.op = 2'(OP_SUB); e.res = 2'(R_ALUOUT);
                e.pc_write = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
                push(e, rbit(), z, ins);
                if (f3 == 3'b000 || f3 == 3'b001) m_ret++;
                else trap(ins);
            end
            7'b1101111: begin
                e = idle(); e.a = 2'(A_OLD); e.b = 2'(B_FOUR); e.res = 2'(R_ALUOUT); e.pc_write = 1'b1;
                push(e, rbit(), rbit(), ins);
                wb_alu(ins);
            end
            default: trap(ins);
        endcase
    endtask

    function automatic bit legal_op(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
               o == 7'b1100011 || o == 7'b1101111 || o == 7'b0110111;
    endfunction

    task automatic build();
        logic [31:0] ins;
        logic [6:0]  ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b0110111};
        cyc_t        c0;
        m_ret = 0;
        c0.rst_n = 1'b0; c0.ready = 1'b0; c0.zero = 1'b0; c0.chk = 1'b0;
        c0.instr = '0; c0.e = '0;
        q.push_back(c0);
        reset_tail(32'h0);
        add_instr(32'h00500093, 0, 0, 1'b0, 1'b0);   // addi x1,x0,5
        add_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);   // lw x2,0(x1)
        add_instr(32'h00209463, 0, 0, 1'b0, 1'b0);   // bne x1,x2,8
        add_instr(32'h00209463, 0, 0, 1'b1, 1'b0);
        add_instr(32'h008000EF, 0, 0, 1'b0, 1'b0);   // jal x1,8
        add_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
        add_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        add_instr(32'h0000A103, 0, 1, 1'b0, 1'b1);   // aborted in memory read
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 99);
            ins = $urandom;
            if (r < 3) begin
                do ins[6:0] = 7'($urandom); while (legal_op(ins[6:0]));
            end else begin
                ins[6:0] = ops[$urandom_range(0, 6)];
                if (ins[6:0] == 7'b1100011)
                    ins[14:12] = (r < 6) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            end
            add_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), 1'b0);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic lit_checks(input int cyc);
        case (cyc)
            1:  lit("reset_instret", instret, 0);
            4:  lit("addi_decode_imm_b", 32'(imm_src), 3);
            5:  begin lit("addi_exec_imm_i", 32'(imm_src), 1); lit("addi_no_wb_yet", 32'(reg_write), 0); end
            6:  begin lit("addi_wb", 32'(reg_write), 1); lit("addi_instret_pre", instret, 0); end
            7:  lit("addi_instret_post", instret, 1);
            10, 11, 12, 13: lit("lw_mem_req_hold", 32'(mem_req), 1);
            14: lit("lw_wb_mem", 32'(reg_write), 1);
            15: lit("lw_instret", instret, 2);
            16: lit("bne_decode_imm_b", 32'(imm_src), 3);
            17: lit("bne_taken_pc_write", 32'(pc_write), 1);
            20: lit("bne_not_taken_pc_write", 32'(pc_write), 0);
            22: lit("jal_decode_imm_j", 32'(imm_src), 5);
            23: lit("jal_pc_write", 32'(pc_write), 1);
            24: lit("jal_wb", 32'(reg_write), 1);
            25: lit("jal_instret", instret, 5);
            32: begin lit("trap_sticky", 32'(illegal_instr), 1); lit("trap_no_req", 32'(mem_req), 0);
                      lit("trap_instret_frozen", instret, 5); end
            42: lit("memrd_req_before_reset", 32'(mem_req), 1);
            43: begin lit("reset_drops_req", 32'(mem_req), 0); lit("reset_instret_clr", instret, 0); end
            45: lit("fetch_after_release", 32'(mem_req), 1);
            default: begin end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t c;
        exp_t act;
        int   cyc = 0;
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = '0;
        build();
        @(posedge clk); #1;
        while (q.size() > 0) begin
            c = q.pop_front();
            rst_n = c.rst_n; mem_ready = c.ready; zero = c.zero; instr = c.instr;
            @(negedge clk);
            if (c.chk) begin
                act = '{mem_req: mem_req, mem_we: mem_we, addr_src: addr_src, ir_write: ir_write,
                        pc_write: pc_write, reg_write: reg_write, imm: imm_src, a: alu_src_a,
                        b: alu_src_b, op: alu_op, res: result_src, ill: illegal_instr, ret: instret};
                total++;
                if (act === c.e) passed++;
                else $display("FAIL cycle %0d outputs: actual=%h required=%h", cyc, act, c.e);
            end
            lit_checks(cyc);
            @(posedge clk); #1;
            cyc++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
